// File: rtl/rect_fill_writer.sv
// Rectangle-fill write engine for the 640x480x12 framebuffer: accepts a fill
// command, clips it to the visible area and writes it pixel by pixel, row-major.
module rect_fill_writer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 12
) (
    input  logic               vga_clk,
    input  logic               clrn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [9:0]         cmd_x,
    input  logic [8:0]         cmd_y,
    input  logic [9:0]         cmd_w,
    input  logic [8:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    input  logic               wr_grant,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [10:0]       H_LIM  = 11'(H_RES);
    localparam logic [9:0]        V_LIM  = 10'(V_RES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

    // Start address of a line; the common 640-wide case is two shifts and an add.
    function automatic logic [ADDR_W-1:0] row_base(input logic [8:0] y);
        logic [ADDR_W-1:0] ye;
        ye = ADDR_W'(y);
        if (H_RES == 640) begin
            return (ye << 9) + (ye << 7);
        end else begin
            return ye * H_STEP;
        end
    endfunction

    state_t               state_r, state_s;
    logic [9:0]           x_r, x_s, w_r, w_s, x_end_r, x_end_s, col_r, col_s;
    logic [8:0]           y_r, y_s, h_r, h_s, y_end_r, y_end_s, row_r, row_s;
    logic [COLOR_W-1:0]   color_r, color_s, wr_data_s;
    logic [ADDR_W-1:0]    line_base_r, line_base_s, wr_addr_s, base_s;
    logic                 wr_en_s, busy_s, done_s;
    logic [10:0]          x_sum_s, x_lim_s;
    logic [9:0]           y_sum_s, y_lim_s;
    logic                 empty_s;
    logic [9:0]           clip_x_end_s;
    logic [8:0]           clip_y_end_s;

    assign cmd_ready = (state_r == IDLE);

    // Clip geometry of the latched command; sums are one bit wider so they cannot wrap.
    assign x_sum_s      = {1'b0, x_r} + {1'b0, w_r};
    assign y_sum_s      = {1'b0, y_r} + {1'b0, h_r};
    assign x_lim_s      = (x_sum_s > H_LIM) ? H_LIM : x_sum_s;
    assign y_lim_s      = (y_sum_s > V_LIM) ? V_LIM : y_sum_s;
    assign clip_x_end_s = 10'(x_lim_s - 11'd1);
    assign clip_y_end_s = 9'(y_lim_s - 10'd1);
    assign empty_s      = (w_r == 10'd0) || (h_r == 9'd0) ||
                          ({1'b0, x_r} >= H_LIM) || ({1'b0, y_r} >= V_LIM);
    assign base_s       = row_base(y_r);

    // Next-state and next-register logic for the whole engine.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_s         = y_r;
        w_s         = w_r;
        h_s         = h_r;
        color_s     = color_r;
        x_end_s     = x_end_r;
        y_end_s     = y_end_r;
        col_s       = col_r;
        row_s       = row_r;
        line_base_s = line_base_r;
        wr_en_s     = wr_en;
        wr_addr_s   = wr_addr;
        wr_data_s   = wr_data;
        busy_s      = busy;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    x_s     = cmd_x;
                    y_s     = cmd_y;
                    w_s     = cmd_w;
                    h_s     = cmd_h;
                    color_s = cmd_color;
                    busy_s  = 1'b1;
                    state_s = SETUP;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            SETUP: begin
                if (empty_s) begin
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    x_end_s     = clip_x_end_s;
                    y_end_s     = clip_y_end_s;
                    col_s       = x_r;
                    row_s       = y_r;
                    line_base_s = base_s;
                    wr_addr_s   = base_s + ADDR_W'(x_r);
                    wr_data_s   = color_r;
                    wr_en_s     = 1'b1;
                    state_s     = FILL;
                end
            end
            FILL: begin
                // Address and data hold while the arbiter withholds the grant.
                if (wr_grant) begin
                    if (col_r != x_end_r) begin
                        col_s     = col_r + 10'd1;
                        wr_addr_s = wr_addr + A_ONE;
                    end else if (row_r != y_end_r) begin
                        row_s       = row_r + 9'd1;
                        col_s       = x_r;
                        line_base_s = line_base_r + H_STEP;
                        wr_addr_s   = line_base_r + H_STEP + ADDR_W'(x_r);
                    end else begin
                        wr_en_s = 1'b0;
                        done_s  = 1'b1;
                        state_s = DONE;
                    end
                end else begin
                    wr_en_s = 1'b1;
                end
            end
            DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                wr_en_s = 1'b0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; all clear asynchronously.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state_r     <= IDLE;
            x_r         <= 10'd0;
            y_r         <= 9'd0;
            w_r         <= 10'd0;
            h_r         <= 9'd0;
            color_r     <= '0;
            x_end_r     <= 10'd0;
            y_end_r     <= 9'd0;
            col_r       <= 10'd0;
            row_r       <= 9'd0;
            line_base_r <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            w_r         <= w_s;
            h_r         <= h_s;
            color_r     <= color_s;
            x_end_r     <= x_end_s;
            y_end_r     <= y_end_s;
            col_r       <= col_s;
            row_r       <= row_s;
            line_base_r <= line_base_s;
            wr_en       <= wr_en_s;
            wr_addr     <= wr_addr_s;
            wr_data     <= wr_data_s;
            busy        <= busy_s;
            done        <= done_s;
        end
    end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed and randomized checks of rect_fill_writer against a clipped-rectangle
// reference model (nested loops over the visible pixels of each command).
module tb_rect_fill_writer;

    logic        vga_clk = 1'b0;
    logic        clrn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [11:0] cmd_color;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_grant;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int got_addr[$];
    int got_data[$];
    int got_edge[$];
    int done_q[$];
    int exp_addr[$];

    logic        stall_pend = 1'b0;
    logic [18:0] held_addr;
    logic [11:0] held_data;
    logic        alt_g = 1'b0;

    rect_fill_writer dut (
        .vga_clk  (vga_clk),
        .clrn     (clrn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x    (cmd_x),
        .cmd_y    (cmd_y),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_color(cmd_color),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_grant (wr_grant),
        .busy     (busy),
        .done     (done)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample outputs for the coming edge (cyc), then cross it.
    task automatic step();
        if (stall_pend) begin
            check("stall_addr", 32'(wr_addr), 32'(held_addr));
            check("stall_data", 32'(wr_data), 32'(held_data));
        end
        stall_pend = (wr_en === 1'b1) && (wr_grant === 1'b0);
        held_addr  = wr_addr;
        held_data  = wr_data;
        if (wr_en === 1'b1 && wr_grant === 1'b1) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
            got_edge.push_back(cyc);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        @(posedge vga_clk);
        #1;
        cyc++;
    endtask

    // Reference: every visible pixel of the rectangle, row-major.
    task automatic build_model(input int x, input int y, input int w, input int h);
        int xe, ye;
        exp_addr.delete();
        if (w == 0 || h == 0 || x >= 640 || y >= 480) return;
        xe = (x + w > 640) ? 640 : x + w;
        ye = (y + h > 480) ? 480 : y + h;
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                exp_addr.push_back(r * 640 + c);
    endtask

    function automatic logic pick_grant(input int gmode);
        if (gmode == 0) return 1'b1;
        if (gmode == 1) begin
            alt_g = ~alt_g;
            return alt_g;
        end
        return 1'($urandom);
    endfunction

    task automatic start_cmd(input int x, input int y, input int w, input int h,
                             input logic [11:0] color, output int n_edge);
        for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) step();
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        got_addr.delete();
        got_data.delete();
        got_edge.delete();
        done_q.delete();
        cmd_x     = 10'(x);
        cmd_y     = 9'(y);
        cmd_w     = 10'(w);
        cmd_h     = 9'(h);
        cmd_color = color;
        cmd_valid = 1'b1;
        n_edge    = cyc;
        step();
        cmd_valid = 1'b0;
        cmd_x     = 10'($urandom);
        cmd_y     = 9'($urandom);
        cmd_w     = 10'($urandom);
        cmd_h     = 9'($urandom);
        cmd_color = 12'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("ready_low_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [11:0] color, input int gmode);
        int n0, n, budget;
        build_model(x, y, w, h);
        n      = exp_addr.size();
        budget = 10 * n + 50;
        alt_g  = 1'b1;
        start_cmd(x, y, w, h, color, n0);
        for (int k = 0; k < budget && done_q.size() == 0; k++) begin
            wr_grant = pick_grant(gmode);
            step();
        end
        check("done_seen", 32'(done_q.size()), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(cmd_ready), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("write_count", 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            check("write_addr", 32'(got_addr[i]), 32'(exp_addr[i]));
            check("write_data", 32'(got_data[i]), 32'(color));
        end
        if (gmode == 0 && done_q.size() == 1) begin
            check("done_latency", 32'(done_q[0] - n0), 32'(n + 2));
            if (n > 0 && got_edge.size() == n) begin
                check("first_write_latency", 32'(got_edge[0] - n0), 32'd2);
                check("last_write_latency", 32'(got_edge[n-1] - n0), 32'(n + 1));
            end
        end
        wr_grant = 1'b1;
    endtask

    initial begin
        int n0, rx, ry, rw, rh, rg;
        clrn      = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = 10'd0;
        cmd_y     = 9'd0;
        cmd_w     = 10'd0;
        cmd_h     = 9'd0;
        cmd_color = 12'd0;
        wr_grant  = 1'b1;
        #2 clrn = 1'b0;
        @(posedge vga_clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        clrn = 1'b1;
        step();

        run_cmd(0, 0, 1, 1, 12'hF00, 0);
        run_cmd(10, 20, 4, 3, 12'h0AB, 0);
        run_cmd(10, 20, 4, 3, 12'h0AB, 1);
        run_cmd(638, 479, 5, 4, 12'h0F0, 0);
        run_cmd(5, 5, 0, 3, 12'h123, 0);
        run_cmd(5, 5, 3, 0, 12'h123, 0);
        run_cmd(700, 5, 3, 3, 12'h123, 0);
        run_cmd(5, 480, 3, 3, 12'h123, 0);
        run_cmd(0, 479, 1023, 1, 12'hABC, 2);

        // Reset after the fifth write of a 4x3 fill.
        start_cmd(10, 20, 4, 3, 12'h0AB, n0);
        for (int k = 0; k < 40 && got_addr.size() < 5; k++) step();
        check("pre_reset_writes", 32'(got_addr.size()), 32'd5);
        clrn = 1'b0;
        #1;
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_done", 32'(done), 32'd0);
        stall_pend = 1'b0;
        step();
        step();
        clrn = 1'b1;
        step();
        check("rst_no_done", 32'(done_q.size()), 32'd0);
        check("rst_no_writes", 32'(got_addr.size()), 32'd5);
        run_cmd(1, 1, 2, 1, 12'h555, 0);

        for (int t = 0; t < 12; t++) begin
            rx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 700)) : int'($urandom_range(625, 645));
            ry = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 500)) : int'($urandom_range(470, 485));
            rw = int'($urandom_range(0, 14));
            rh = int'($urandom_range(0, 6));
            rg = int'($urandom_range(0, 2));
            run_cmd(rx, ry, rw, rh, 12'($urandom), rg);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
